// File: rtl/fir_128_mdc_tile_sequencer.sv
// Tile sequencer for the 128-tap MDC FIR kernel adapter.
// Starts the kernel, counts output beats, and flags completion or a stall.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   test_mode_i          unused
//   clear_i              synchronous soft clear
//   cfg_start_i          tile start request
//   cfg_len_i            kernel outputs expected in the tile
//   kernel_ready_i       kernel accepted its first input
//   kernel_done_i        one pulse per kernel output beat
//   kernel_idle_i        kernel idle flag
//   kernel_start_o       one-cycle start pulse to the kernel
//   busy_o               tile in progress
//   tile_done_o          one-cycle completion pulse
//   out_cnt_o            beats counted in current or last tile
//   err_o                sticky watchdog error
//
// Macro FIR_128_MDC_SEQ_TIMEOUT_EN enables the stall watchdog.
// Without it, err_o is tied low.
//
// Pulse and busy outputs are flops loaded from the current state,
// so they trail the state by one cycle; out_cnt_o and err_o are
// updated on the edge that changes them.

module fir_128_mdc_tile_sequencer #(
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             test_mode_i,
   input  logic             clear_i,
   input  logic             cfg_start_i,
   input  logic [CNT_W-1:0] cfg_len_i,
   input  logic             kernel_ready_i,
   input  logic             kernel_done_i,
   input  logic             kernel_idle_i,
   output logic             kernel_start_o,
   output logic             busy_o,
   output logic             tile_done_o,
   output logic [CNT_W-1:0] out_cnt_o,
   output logic             err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_ACK,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_nxt;
   logic             kst_q, busy_q, tdone_q;
   logic             active, accept;
   logic             cnt_inc, cnt_full;
   logic             wd_fire;
   logic             unused_test;

   assign unused_test = test_mode_i;

   assign active  = (state_q == S_WAIT_ACK) ||
                    (state_q == S_RUN);
   assign accept  = (state_q == S_IDLE) && cfg_start_i;
   assign cnt_nxt = cnt_q + CNT_W'(1);

   // Beats beyond the tile length are dropped, so the
   // counter saturates at the latched length.
   assign cnt_inc  = active && kernel_done_i &&
                     (cnt_q != len_q);
   assign cnt_full = cnt_inc && (cnt_nxt == len_q);

`ifdef FIR_128_MDC_SEQ_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
   logic            wd_evt;

   // Any ready or done beat counts as progress.
   assign wd_evt  = kernel_ready_i || kernel_done_i;
   assign wd_fire = active && !wd_evt &&
                    (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wd_d  = '0;
      err_d = err_q;
      if (active && !wd_evt && !clear_i) begin
         wd_d = wd_q + WD_W'(1);
      end
      if (clear_i || accept) begin
         err_d = 1'b0;
      end else if (wd_fire) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;

   assign wd_fire = 1'b0;
   assign err_o   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (cfg_start_i) begin
                  cnt_d = '0;
                  if (cfg_len_i != '0) begin
                     len_d   = cfg_len_i;
                     state_d = S_START;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_START: begin
               state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               // A done beat implies the kernel took
               // its input, even without ready.
               if (cnt_inc) begin
                  cnt_d   = cnt_nxt;
                  state_d = cnt_full ? S_DONE : S_RUN;
               end else if (kernel_ready_i &&
                            !kernel_idle_i) begin
                  state_d = S_RUN;
               end else if (wd_fire) begin
                  state_d = S_IDLE;
               end
            end
            S_RUN: begin
               if (cnt_inc) begin
                  cnt_d = cnt_nxt;
                  if (cnt_full) begin
                     state_d = S_DONE;
                  end
               end else if (wd_fire) begin
                  state_d = S_IDLE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         kst_q   <= 1'b0;
         busy_q  <= 1'b0;
         tdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         kst_q   <= !clear_i && (state_q == S_START);
         busy_q  <= !clear_i && (state_q != S_IDLE);
         tdone_q <= !clear_i && (state_q == S_DONE);
      end
   end

   assign kernel_start_o = kst_q;
   assign busy_o         = busy_q;
   assign tile_done_o    = tdone_q;
   assign out_cnt_o      = cnt_q;

endmodule

// File: tb/tb_fir_128_mdc_tile_sequencer.sv
// Self-checking bench for fir_128_mdc_tile_sequencer.
// Directed tiles plus randomized tiles against a timeline model.

module tb_fir_128_mdc_tile_sequencer;

   localparam int CW = 16;
   localparam int TO = 16;
`ifdef FIR_128_MDC_SEQ_TIMEOUT_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          test_mode = 1'b0;
   logic          clr = 1'b0;
   logic          st = 1'b0;
   logic [CW-1:0] len = '0;
   logic          rdy = 1'b0;
   logic          dn = 1'b0;
   logic          idl = 1'b0;
   logic          kst, busy, tdone, err;
   logic [CW-1:0] cnt;

   int n_chk = 0;
   int n_fail = 0;

   bit rdy_s[64];
   bit dn_s[64];
   bit idl_s[64];
   bit st_s[64];

   fir_128_mdc_tile_sequencer #(
      .CNT_W(CW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .test_mode_i(test_mode),
      .clear_i(clr),
      .cfg_start_i(st),
      .cfg_len_i(len),
      .kernel_ready_i(rdy),
      .kernel_done_i(dn),
      .kernel_idle_i(idl),
      .kernel_start_o(kst),
      .busy_o(busy),
      .tile_done_o(tdone),
      .out_cnt_o(cnt),
      .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag,
                          input bit e_kst,
                          input bit e_busy,
                          input bit e_td,
                          input int e_cnt,
                          input bit e_err);
      chk({tag, ".kst"}, {31'd0, kst}, {31'd0, e_kst});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
      chk({tag, ".tdone"}, {31'd0, tdone}, {31'd0, e_td});
      chk({tag, ".cnt"}, {16'd0, cnt}, e_cnt);
      chk({tag, ".err"}, {31'd0, err}, {31'd0, e_err});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit s, input int l,
                        input bit r, input bit d,
                        input bit i, input bit c);
      st  = s;
      len = CW'(l);
      rdy = r;
      dn  = d;
      idl = i;
      clr = c;
      tick();
   endtask

   task automatic clr_arrays();
      for (int i = 0; i < 64; i++) begin
         rdy_s[i] = 1'b0;
         dn_s[i]  = 1'b0;
         idl_s[i] = 1'b0;
         st_s[i]  = 1'b0;
      end
   endtask

   // Edge 1 issues the request; kernel inputs from edge 3 on
   // can count. Tile ends on edge f (len-th done, or 1 for a
   // zero-length tile): pulse at f+1, busy over edges 2..f+1.
   task automatic run_tile(input int tl, input int ne,
                           input string tag);
      int f;
      int dones;
      int e_cnt;
      bit s;
      int l;
      f = 0;
      dones = 0;
      if (tl == 0) begin
         f = 1;
      end else begin
         for (int e = 3; e < ne; e++) begin
            if (dn_s[e]) begin
               dones++;
               if (dones == tl && f == 0) f = e;
            end
         end
      end
      dones = 0;
      for (int e = 1; e < ne; e++) begin
         s = (e == 1) ? 1'b1 :
             ((e <= f + 1) ? st_s[e] : 1'b0);
         l = (e == 1) ? tl : int'($urandom_range(0, 7));
         drive(s, l, rdy_s[e], dn_s[e], idl_s[e], 1'b0);
         if (e >= 3 && dn_s[e]) dones++;
         e_cnt = (dones < tl) ? dones : tl;
         chk_all($sformatf("%s.e%0d", tag, e),
                 (tl != 0) && (e == 2),
                 (e >= 2) && (e <= f + 1),
                 e == f + 1, e_cnt, 1'b0);
      end
   endtask

   initial begin
      int e;
      int gap;
      int dones;
      int tl;
      bit d;

      // reset state
      repeat (2) tick();
      chk_all("reset", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      repeat (2) tick();
      chk_all("post_reset", 0, 0, 0, 0, 0);

      // len 4, ready 3 cycles after the start pulse, 4 dones
      clr_arrays();
      rdy_s[5] = 1'b1;
      for (int i = 6; i <= 9; i++) dn_s[i] = 1'b1;
      run_tile(4, 13, "len4");

      // zero-length tile
      clr_arrays();
      dn_s[2] = 1'b1;
      dn_s[3] = 1'b1;
      run_tile(0, 5, "len0");

      // ready+done together, then surplus dones
      clr_arrays();
      rdy_s[3] = 1'b1;
      for (int i = 3; i <= 6; i++) dn_s[i] = 1'b1;
      run_tile(2, 9, "len2");

      // randomized tiles
      for (int t = 0; t < 6; t++) begin
         clr_arrays();
         tl = int'($urandom_range(1, 5));
         e = 3;
         gap = 0;
         dones = 0;
         while (dones < tl) begin
            d = ($urandom_range(0, 1) == 1) || (gap >= 4);
            dn_s[e]  = d;
            rdy_s[e] = $urandom_range(0, 1) == 1;
            idl_s[e] = $urandom_range(0, 1) == 1;
            if (d) begin
               dones++;
               gap = 0;
            end else begin
               gap++;
            end
            e++;
         end
         dn_s[e]     = $urandom_range(0, 1) == 1;
         dn_s[e + 1] = $urandom_range(0, 1) == 1;
         for (int i = 2; i < e + 2; i++) begin
            st_s[i] = $urandom_range(0, 3) == 0;
         end
         run_tile(tl, e + 5, $sformatf("rnd%0d", t));
      end

      // restart ignored in RUN, then clear at count 3
      drive(1, 5, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      chk_all("clr.cnt3", 0, 1, 0, 3, 0);
      drive(1, 2, 0, 0, 0, 0);
      chk_all("clr.restart", 0, 1, 0, 3, 0);
      drive(0, 0, 0, 1, 0, 1);
      chk_all("clr.edge", 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 1, 0, 0);
         chk_all($sformatf("clr.after%0d", i),
                 0, 0, 0, 0, 0);
      end

      // async reset mid-tile
      drive(1, 3, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      chk_all("rst.run", 0, 1, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("rst.async", 0, 0, 0, 0, 0);
      tick();
      chk_all("rst.held", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 1, 0, 0);
         chk_all($sformatf("rst.after%0d", i),
                 0, 0, 0, 0, 0);
      end

      // stall after ready: watchdog fires 16 cycles later
      drive(1, 4, 0, 0, 0, 0);
      for (int k = 2; k <= 25; k++) begin
         drive(0, 0, k == 5, 0, 0, 0);
         if (k >= 6) begin
            chk_all($sformatf("wd.e%0d", k), 0,
                    WD_ON ? (k <= 5 + TO) : 1'b1, 0, 0,
                    WD_ON && (k >= 5 + TO));
         end
      end
      drive(1, 0, 0, 0, 0, 0);
      chk_all("wd.restart", 0, !WD_ON, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk_all("wd.done", 0, 1, WD_ON, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      chk_all("wd.clear", 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk_all("wd.idle", 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
